master_volume_ramp: RTL and testbench
=====================================

MASTER_VOLUME_RAMP -- requirements
Module: master_volume_ramp

Interface
REQ-001 Parameter SAMPLE_WIDTH, default SAMPLE_WIDTH from opl3_pkg (16), width of signed stereo samples in and out.
REQ-002 Parameter VOL_WIDTH, default 8, width of the volume target.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 channel_valid  input  1  one-cycle pulse: clamped stereo channel sample available.
REQ-006 channel_l  input  SAMPLE_WIDTH  signed left channel sample, sampled when channel_valid=1.
REQ-007 channel_r  input  SAMPLE_WIDTH  signed right channel sample, sampled when channel_valid=1.
REQ-008 vol_target  input  VOL_WIDTH  requested master volume; 0 silent, 255 unity.
REQ-009 mute  input  1  forces the effective target to 0 while high.
REQ-010 sample_valid  output  1  one-cycle pulse: sample_l/sample_r updated.
REQ-011 sample_l  output  SAMPLE_WIDTH  signed scaled left sample.
REQ-012 sample_r  output  SAMPLE_WIDTH  signed scaled right sample.
REQ-013 gain  output  VOL_WIDTH+1  current applied gain, 0..256.
REQ-014 busy  output  1  high whenever the state machine is not IDLE.
REQ-015 sample_dropped  output  1  one-cycle pulse when channel_valid arrives while busy.

Function
REQ-016 Effective target: 0 if mute=1; else 256 if vol_target=255; else vol_target zero-extended.
REQ-017 States IDLE, MUL_L, MUL_R, OUTPUT; IDLE->MUL_L on channel_valid; MUL_L->MUL_R->OUTPUT->IDLE unconditionally.
REQ-018 On acceptance (IDLE and channel_valid): latch channel_l/channel_r; step gain one unit toward effective target (+1 if below, -1 if above, unchanged if equal).
REQ-019 Target and mute are sampled only at acceptance; changes mid-sample do not affect the sample in flight.
REQ-020 The stepped gain takes effect for the sample being accepted.
REQ-021 MUL_L computes sample_l = (latched_l * gain) >>> 8 (signed x unsigned, arithmetic shift, floor rounding) into an internal register.
REQ-022 MUL_R computes the right result the same way. One shared multiplier; product width SAMPLE_WIDTH+VOL_WIDTH+2.
REQ-023 Results need no clamp: gain<=256 bounds every result to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
REQ-024 In OUTPUT, sample_l/sample_r update simultaneously and sample_valid=1 for exactly one cycle; outputs then hold until the next OUTPUT.
REQ-025 Latency: channel_valid in cycle N -> sample_valid in cycle N+3.
REQ-026 channel_valid while busy=1 is discarded: no latch, no gain step; sample_dropped pulses in the same cycle.
REQ-027 A new channel_valid in the cycle after OUTPUT (IDLE) is accepted normally; back-to-back throughput is one sample per 4 cycles.
REQ-028 Gain saturates at 0 and 256; it never wraps.

Reset
REQ-029 Reset forces IDLE; sample_l=0, sample_r=0, sample_valid=0, sample_dropped=0, busy=0, gain=0, latched samples=0.
REQ-030 Reset mid-operation abandons the sample in flight; no sample_valid is produced for it.
REQ-031 After reset, gain ramps up from 0, giving a click-free fade-in.

Structure
REQ-032 SAMPLE_WIDTH stays in opl3_pkg; a new VOL_WIDTH localparam and a state enum type are added to opl3_pkg.
REQ-033 Single module, no sub-modules; the shared multiplier is inferred inline.
REQ-034 The block sits between channel accumulation and dac_prep, consuming channel_valid/channel_l/channel_r.

Verification
REQ-035 Reset, vol_target=255, 300 samples of L=1000/R=-1000 -> gain reaches 256 by the 256th sample, output L=1000/R=-1000 thereafter.
REQ-036 Gain=128 steady, L=-3, R=32767 -> sample_l=-2 (floor), sample_r=16383, sample_valid 3 cycles after channel_valid.
REQ-037 Gain=256, mute asserted, 10 samples of L=R=-32768 -> gain 246 after 10 samples, last output (-32768*246)>>>8 = -31488.
REQ-038 channel_valid at N and N+2 -> second pulse dropped, sample_dropped=1 at N+2, exactly one sample_valid at N+3, gain stepped once.
REQ-039 Reset asserted at N+1 after acceptance at N -> no sample_valid; all outputs 0; busy=0.
REQ-040 vol_target changed from 10 to 0 at N+1 after acceptance at N with gain=10 -> in-flight sample uses gain 10; the next accepted sample uses gain 9.

Source files
------------

// File: rtl/opl3_pkg.sv
// Shared OPL3 audio-path constants and types used by the master volume stage.
package opl3_pkg;

  localparam int SAMPLE_WIDTH = 16;
  localparam int VOL_WIDTH    = 8;

  typedef enum logic [1:0] {
    VR_IDLE,
    VR_MUL_L,
    VR_MUL_R,
    VR_OUTPUT
  } vol_ramp_state_t;

endpackage

// File: rtl/master_volume_ramp.sv
// Master volume stage: per-sample one-step gain ramp toward the target and a
// shared sequential multiplier scaling left then right channel samples.
module master_volume_ramp
  import opl3_pkg::*;
#(
  parameter int SAMPLE_WIDTH = opl3_pkg::SAMPLE_WIDTH,
  parameter int VOL_WIDTH    = opl3_pkg::VOL_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           channel_valid,
  input  logic signed [SAMPLE_WIDTH-1:0] channel_l,
  input  logic signed [SAMPLE_WIDTH-1:0] channel_r,
  input  logic        [VOL_WIDTH-1:0]    vol_target,
  input  logic                           mute,
  output logic                           sample_valid,
  output logic signed [SAMPLE_WIDTH-1:0] sample_l,
  output logic signed [SAMPLE_WIDTH-1:0] sample_r,
  output logic        [VOL_WIDTH:0]      gain,
  output logic                           busy,
  output logic                           sample_dropped
);

  localparam int GAIN_WIDTH = VOL_WIDTH + 1;
  localparam int PROD_WIDTH = SAMPLE_WIDTH + VOL_WIDTH + 2;

  vol_ramp_state_t state, state_next;

  logic                           accept;
  logic        [GAIN_WIDTH-1:0]   eff_target;
  logic        [GAIN_WIDTH-1:0]   gain_stepped;
  logic signed [SAMPLE_WIDTH-1:0] latched_l;
  logic signed [SAMPLE_WIDTH-1:0] latched_r;
  logic signed [SAMPLE_WIDTH-1:0] result_l;
  logic signed [SAMPLE_WIDTH-1:0] mul_operand;
  logic signed [PROD_WIDTH-1:0]   product;
  logic signed [SAMPLE_WIDTH-1:0] scaled;
  logic                           unused_product_bits;

  // Full-scale volume code maps to exact unity (256) rather than 255/256.
  always_comb begin
    eff_target = '0;
    if (mute) begin
      eff_target = '0;
    end else if (&vol_target) begin
      eff_target = {1'b1, {VOL_WIDTH{1'b0}}};
    end else begin
      eff_target = {1'b0, vol_target};
    end
  end

  always_comb begin
    gain_stepped = gain;
    if (gain < eff_target) begin
      gain_stepped = gain + 1'b1;
    end else if (gain > eff_target) begin
      gain_stepped = gain - 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      VR_IDLE:   if (channel_valid) state_next = VR_MUL_L;
      VR_MUL_L:  state_next = VR_MUL_R;
      VR_MUL_R:  state_next = VR_OUTPUT;
      VR_OUTPUT: state_next = VR_IDLE;
      default:   state_next = VR_IDLE;
    endcase
  end

  assign accept         = (state == VR_IDLE) && channel_valid;
  assign busy           = (state != VR_IDLE);
  assign sample_dropped = channel_valid && busy;
  assign sample_valid   = (state == VR_OUTPUT);

  // Single multiplier time-shared between channels; gain is zero-extended so
  // the product is signed x unsigned, and >>> 8 floors toward -infinity.
  assign mul_operand = (state == VR_MUL_L) ? latched_l : latched_r;
  assign product     = mul_operand * $signed({1'b0, gain});
  assign scaled      = product[SAMPLE_WIDTH+7:8];
  assign unused_product_bits = ^{product[PROD_WIDTH-1:SAMPLE_WIDTH+8], product[7:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= VR_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gain      <= '0;
      latched_l <= '0;
      latched_r <= '0;
      result_l  <= '0;
      sample_l  <= '0;
      sample_r  <= '0;
    end else begin
      if (accept) begin
        latched_l <= channel_l;
        latched_r <= channel_r;
        gain      <= gain_stepped;
      end
      if (state == VR_MUL_L) begin
        result_l <= scaled;
      end
      // Both outputs load on entry to OUTPUT so they change together.
      if (state == VR_MUL_R) begin
        sample_l <= result_l;
        sample_r <= scaled;
      end
    end
  end

endmodule

// File: tb/tb_master_volume_ramp.sv
// Directed self-checking bench for master_volume_ramp.
module tb_master_volume_ramp;

  logic               clk;
  logic               reset;
  logic               channel_valid;
  logic signed [15:0] channel_l;
  logic signed [15:0] channel_r;
  logic        [7:0]  vol_target;
  logic               mute;
  logic               sample_valid;
  logic signed [15:0] sample_l;
  logic signed [15:0] sample_r;
  logic        [8:0]  gain;
  logic               busy;
  logic               sample_dropped;

  int total;
  int bad;

  master_volume_ramp #(
    .SAMPLE_WIDTH(16),
    .VOL_WIDTH(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .channel_valid (channel_valid),
    .channel_l     (channel_l),
    .channel_r     (channel_r),
    .vol_target    (vol_target),
    .mute          (mute),
    .sample_valid  (sample_valid),
    .sample_l      (sample_l),
    .sample_r      (sample_r),
    .gain          (gain),
    .busy          (busy),
    .sample_dropped(sample_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] observed,
                       input logic signed [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Presents one sample for a single cycle; returns at the negedge of the
  // cycle after acceptance (first busy cycle).
  task automatic pulse(input logic signed [15:0] l, input logic signed [15:0] r);
    @(negedge clk);
    channel_valid = 1'b1;
    channel_l     = l;
    channel_r     = r;
    @(negedge clk);
    channel_valid = 1'b0;
  endtask

  // Returns at the negedge of the OUTPUT cycle (N+3) with sample_valid checked.
  task automatic run_sample(input logic signed [15:0] l, input logic signed [15:0] r);
    pulse(l, r);
    repeat (2) @(negedge clk);
    check("valid_at_n3", 32'(sample_valid), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic seen;
    total         = 0;
    bad           = 0;
    reset         = 1'b1;
    channel_valid = 1'b0;
    channel_l     = '0;
    channel_r     = '0;
    vol_target    = 8'd0;
    mute          = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_gain", 32'(gain), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_dropped", 32'(sample_dropped), 0);
    check("rst_l", sample_l, 0);
    check("rst_r", sample_r, 0);
    reset = 1'b0;

    // Fade-in from 0 to unity
    vol_target = 8'd255;
    for (int i = 1; i <= 300; i++) begin
      run_sample(16'sd1000, -16'sd1000);
      check("ramp_gain", 32'(gain), (i < 256) ? i : 256);
      if (i == 1) begin
        check("ramp1_l", sample_l, 3);
        check("ramp1_r", sample_r, -4);
      end
      if (i == 128) begin
        check("ramp128_l", sample_l, 500);
        check("ramp128_r", sample_r, -500);
      end
      if (i == 256 || i == 300) begin
        check("unity_l", sample_l, 1000);
        check("unity_r", sample_r, -1000);
      end
    end

    // Mute fades down one step per sample
    mute = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      run_sample(-16'sd32768, -16'sd32768);
      if (i == 1) begin
        check("mute1_gain", 32'(gain), 255);
        check("mute1_l", sample_l, -32640);
      end
    end
    check("mute10_gain", 32'(gain), 246);
    check("mute10_l", sample_l, -31488);
    check("mute10_r", sample_r, -31488);
    mute = 1'b0;

    // Target change mid-flight does not affect the sample in flight
    do_reset();
    vol_target = 8'd10;
    repeat (10) run_sample(16'sd1000, 16'sd0);
    check("pre_gain10", 32'(gain), 10);
    pulse(16'sd1000, 16'sd0);
    vol_target = 8'd0;
    repeat (2) @(negedge clk);
    check("inflight_valid", 32'(sample_valid), 1);
    check("inflight_gain", 32'(gain), 10);
    check("inflight_l", sample_l, 39);
    run_sample(16'sd1000, 16'sd0);
    check("next_gain", 32'(gain), 9);
    check("next_l", sample_l, 35);

    // Second pulse two cycles after acceptance is dropped
    pulse(16'sd1000, -16'sd1000);
    @(negedge clk);
    channel_valid = 1'b1;
    channel_l     = 16'sd5000;
    channel_r     = 16'sd5000;
    #1;
    check("drop_pulse", 32'(sample_dropped), 1);
    check("drop_busy", 32'(busy), 1);
    @(negedge clk);
    channel_valid = 1'b0;
    #1;
    check("drop_valid_n3", 32'(sample_valid), 1);
    check("drop_dropped_n3", 32'(sample_dropped), 0);
    check("drop_l", sample_l, 31);
    check("drop_r", sample_r, -32);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (sample_valid) seen = 1'b1;
    end
    check("drop_no_second", 32'(seen), 0);
    check("drop_gain_once", 32'(gain), 8);

    // Reset mid-flight abandons the sample
    pulse(16'sd2000, 16'sd2000);
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_gain", 32'(gain), 0);
    check("midrst_l", sample_l, 0);
    check("midrst_r", sample_r, 0);
    check("midrst_valid", 32'(sample_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (sample_valid) seen = 1'b1;
    end
    check("midrst_no_valid", 32'(seen), 0);

    // Steady half gain with floor rounding and exact latency
    vol_target = 8'd128;
    repeat (128) run_sample(16'sd0, 16'sd0);
    check("half_gain", 32'(gain), 128);
    pulse(-16'sd3, 16'sd32767);
    check("lat_n1", 32'(sample_valid), 0);
    @(negedge clk);
    check("lat_n2", 32'(sample_valid), 0);
    @(negedge clk);
    check("lat_n3", 32'(sample_valid), 1);
    check("half_l", sample_l, -2);
    check("half_r", sample_r, 16383);
    check("half_gain_hold", 32'(gain), 128);
    @(negedge clk);
    check("lat_n4", 32'(sample_valid), 0);
    check("hold_l", sample_l, -2);
    check("hold_r", sample_r, 16383);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
